// File: rtl/hit_uart_tx.sv
// Drains the TDC hit FIFO one word at a time and sends each byte as 8N1 UART, LSB first.
// Start bit begins 3 cycles after data is seen in IDLE; a frame lasts 10*CLKS_PER_BIT cycles.
module hit_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        enable,
  input  logic        fifo_data_available,
  output logic        read_fifo,
  input  logic [7:0]  fifo_dout,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic [15:0] words_sent
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, START, DATA, STOP} state_t;

  state_t      state_q;
  logic [7:0]  shift_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [15:0] words_q;
  logic        tx_q;
  logic        rd_q;
  logic        busy_q;
  logic        baud_tc;

  assign baud_tc = (baud_q == 16'(CLKS_PER_BIT - 1));

  // tx_q is loaded on the edge entering each state, so the line is glitch-free
  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      shift_q <= 8'd0;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      words_q <= 16'd0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && fifo_data_available) begin
            state_q <= READ;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          rd_q    <= 1'b0;
          state_q <= LATCH;
        end
        LATCH: begin
          shift_q <= fifo_dout;
          bit_q   <= 3'd0;
          baud_q  <= 16'd0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (baud_tc) begin
            baud_q  <= 16'd0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_q  <= 16'd0;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud_q  <= 16'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (words_q != 16'hFFFF) begin
              words_q <= words_q + 16'd1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          rd_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign read_fifo  = rd_q;
  assign uart_tx    = tx_q;
  assign tx_busy    = busy_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_hit_uart_tx.sv
// Bench for hit_uart_tx: a timeline model predicts the line, read pulse, busy and word count
// per cycle; directed scenarios add hand-computed literal checks.
module tb_hit_uart_tx;

  localparam int CPB = 4;

  logic        SYSCLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_data_available = 1'b0;
  logic        read_fifo;
  logic [7:0]  fifo_dout = 8'd0;
  logic        uart_tx;
  logic        tx_busy;
  logic [15:0] words_sent;

  hit_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .SYSCLK(SYSCLK),
    .RESET_N(RESET_N),
    .enable(enable),
    .fifo_data_available(fifo_data_available),
    .read_fifo(read_fifo),
    .fifo_dout(fifo_dout),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy),
    .words_sent(words_sent)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct packed {
    logic line;
    logic rd;
    logic last;
  } ev_t;

  // model state (written only by the model process)
  ev_t         mq[$];
  int          mcnt = 0;
  int          cyc = 0;
  ev_t         e;
  logic        was_idle;

  // stimulus / checking state (written only by the main process)
  logic [7:0]  fifo_q[$];
  logic [31:0] base = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rd_cnt = 0;
  int          c0;
  int          c1;
  logic [9:0]  bits;

  task automatic push_frame(input logic [7:0] d);
    mq.push_back('{1'b1, 1'b1, 1'b0});
    mq.push_back('{1'b1, 1'b0, 1'b0});
    for (int i = 0; i < CPB; i++) mq.push_back('{1'b0, 1'b0, 1'b0});
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < CPB; i++) mq.push_back('{d[b], 1'b0, 1'b0});
    for (int i = 0; i < CPB - 1; i++) mq.push_back('{1'b1, 1'b0, 1'b0});
    mq.push_back('{1'b1, 1'b0, 1'b1});
  endtask

  // Each queue entry is the expected output of one cycle; an empty queue means idle.
  always @(posedge SYSCLK) begin
    cyc++;
    if (!RESET_N) begin
      mq.delete();
      mcnt = 0;
    end else begin
      was_idle = (mq.size() == 0);
      if (!was_idle) begin
        e = mq.pop_front();
        if (e.last) mcnt++;
      end
      if (was_idle && enable && fifo_data_available)
        push_frame(fifo_q.size() != 0 ? fifo_q[0] : 8'h00);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] tot;
    logic [15:0] exp_words;
    @(negedge SYSCLK);
    tot = base + 32'(mcnt);
    exp_words = (tot > 32'hFFFF) ? 16'hFFFF : tot[15:0];
    if (mq.size() == 0) begin
      chk("uart_tx", {31'd0, uart_tx}, 32'd1);
      chk("read_fifo", {31'd0, read_fifo}, 32'd0);
      chk("tx_busy", {31'd0, tx_busy}, 32'd0);
    end else begin
      chk("uart_tx", {31'd0, uart_tx}, {31'd0, mq[0].line});
      chk("read_fifo", {31'd0, read_fifo}, {31'd0, mq[0].rd});
      chk("tx_busy", {31'd0, tx_busy}, 32'd1);
    end
    chk("words_sent", {16'd0, words_sent}, {16'd0, exp_words});
    if (read_fifo === 1'b1) begin
      rd_cnt++;
      if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
    end
    fifo_data_available = (fifo_q.size() != 0);
  endtask

  task automatic push_word(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_data_available = 1'b1;
  endtask

  task automatic do_reset(input int n);
    RESET_N = 1'b0;
    base = 0;
    repeat (n) tick();
    RESET_N = 1'b1;
    rd_cnt = 0;
  endtask

  initial begin
    // reset then idle
    do_reset(3);
    repeat (100) tick();
    chk("idle_words", {16'd0, words_sent}, 32'd0);
    chk("idle_busy", {31'd0, tx_busy}, 32'd0);
    chk("idle_rd_cnt", rd_cnt, 0);

    // single word 8'h2D: latency and bit pattern
    enable = 1'b1;
    push_word(8'h2D);
    c0 = cyc;
    c1 = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (uart_tx === 1'b0) begin
        c1 = cyc;
        break;
      end
    end
    chk("start_latency", c1 - c0, 3);
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? 1 : CPB) tick();
      bits[i] = uart_tx;
    end
    repeat (10) tick();
    chk("frame_2D", {22'd0, bits}, 32'h25A);
    chk("single_rd_cnt", rd_cnt, 1);
    chk("single_words", {16'd0, words_sent}, 32'd1);

    // burst of three words
    do_reset(2);
    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h3F);
    repeat (3 * (10 * CPB + 3) + 10) tick();
    chk("burst_rd_cnt", rd_cnt, 3);
    chk("burst_fifo_left", fifo_q.size(), 0);
    chk("burst_words", {16'd0, words_sent}, 32'd3);

    // enable dropped during DATA of word 1
    do_reset(2);
    push_word(8'hA5);
    push_word(8'h5A);
    repeat (20) tick();
    enable = 1'b0;
    repeat (60) tick();
    chk("en_words", {16'd0, words_sent}, 32'd1);
    chk("en_rd_cnt", rd_cnt, 1);
    chk("en_fifo_left", fifo_q.size(), 1);
    enable = 1'b1;
    repeat (50) tick();
    chk("en2_words", {16'd0, words_sent}, 32'd2);
    chk("en2_rd_cnt", rd_cnt, 2);

    // reset during DATA bit 3
    do_reset(2);
    push_word(8'hC3);
    repeat (20) tick();
    RESET_N = 1'b0;
    tick();
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_words", {16'd0, words_sent}, 32'd0);
    tick();
    push_word(8'h96);
    RESET_N = 1'b1;
    repeat (50) tick();
    chk("rst_after_words", {16'd0, words_sent}, 32'd1);

    // saturation: preload count just below the limit
    do_reset(2);
    @(posedge SYSCLK);
    #1;
    dut.words_q = 16'hFFFE;
    base = 32'hFFFE;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (3 * (10 * CPB + 3) + 10) tick();
    chk("sat_words", {16'd0, words_sent}, 32'hFFFF);
    chk("sat_rd_cnt", rd_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
